// File: rtl/aes_pkg.sv
// ============================================================================
//  aes_pkg : shared AES constants, S-box table and GF(2^8) helpers
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int NK_128 = 4;
    localparam int NK_192 = 6;
    localparam int NK_256 = 8;
    localparam int RK_W   = 128;

    typedef logic [1:0] ks_state_t;
    localparam ks_state_t ST_IDLE  = 2'd0;
    localparam ks_state_t ST_GEN   = 2'd1;
    localparam ks_state_t ST_DRAIN = 2'd2;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        int idx;
        idx = 2047 - 8 * int'(x);
        return SBOX_TABLE[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_subword.sv
// ============================================================================
//  aes_subword : four parallel S-box lookups on a 32-bit word
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign word_o[8*b +: 8] = sbox(word_i[8*b +: 8]);
    end

endmodule

`default_nettype wire

// File: rtl/aes_key_expand_seq.sv
// ============================================================================
//  aes_key_expand_seq : one-word-per-clock AES-128/192/256 key schedule,
//                       round keys streamed over a valid/ready handshake
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [32*NK-1:0]   key_in_i,
    output logic               busy_o,
    output logic               rk_valid_o,
    input  logic               rk_ready_i,
    output logic [RK_W-1:0]    rk_data_o,
    output logic [3:0]         rk_idx_o,
    output logic               done_o
);

    localparam int         NR        = nr_of(NK);
    localparam int         LAST_I    = 4 * NR + 3;
    localparam logic [5:0] NK_L      = 6'(NK);
    localparam logic [5:0] LAST_L    = 6'(LAST_I);
    localparam logic [2:0] IMOD_LAST = 3'(NK - 1);
    localparam logic [3:0] NR_L      = 4'(NR);

    if (NK != NK_128 && NK != NK_192 && NK != NK_256) begin : g_bad_nk
        $error("aes_key_expand_seq: NK must be 4, 6 or 8");
    end

    ks_state_t        state_q, state_d;
    logic [31:0]      win_q [NK];
    logic [31:0]      win_d [NK];
    logic [5:0]       i_q, i_d;
    logic [2:0]       imod_q, imod_d;
    logic [7:0]       rcon_q, rcon_d;
    logic [31:0]      asm_q [4];
    logic [31:0]      asm_d [4];
    logic [2:0]       asm_cnt_q, asm_cnt_d;
    logic [RK_W-1:0]  rk_data_q, rk_data_d;
    logic [3:0]       rk_idx_q, rk_idx_d;
    logic [3:0]       key_cnt_q, key_cnt_d;
    logic             rk_valid_q, rk_valid_d;

    logic        asm_full, out_free, xfer, stall, gen_fire, load;
    logic        in_key, rot_sel, last_word, hs;
    logic [31:0] prev_w, sub_in, sub_out, f_w, new_word;
    logic [1:0]  wr_slot;

    assign asm_full  = (asm_cnt_q == 3'd4);
    assign out_free  = !rk_valid_q || rk_ready_i;
    assign xfer      = asm_full && out_free;
    assign stall     = asm_full && !out_free;
    assign gen_fire  = (state_q == ST_GEN) && !stall;
    assign load      = (state_q == ST_IDLE) && start_i;
    assign hs        = rk_valid_q && rk_ready_i;
    assign in_key    = (i_q < NK_L);
    assign rot_sel   = (imod_q == 3'd0);
    assign last_word = (i_q == LAST_L);

    // Window holds w[i-NK] in slot 0 and w[i-1] in slot NK-1; while i<NK the
    // key words simply rotate through, so slot 0 always supplies the base word.
    assign prev_w = win_q[NK-1];
    assign sub_in = rot_sel ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    aes_subword u_subword (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_comb begin
        f_w = prev_w;
        if (rot_sel) begin
            f_w = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == NK_256 && imod_q == 3'd4) begin
            f_w = sub_out;
        end
    end

    assign new_word = in_key ? win_q[0] : (win_q[0] ^ f_w);
    assign wr_slot  = xfer ? 2'd0 : asm_cnt_q[1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i)                            state_d = ST_GEN;
            ST_GEN:   if (gen_fire && last_word)              state_d = ST_DRAIN;
            ST_DRAIN: if (asm_cnt_q == 3'd0 && out_free)      state_d = ST_IDLE;
            default:                                          state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_o = (state_q != ST_IDLE);
        done_o = hs && (rk_idx_q == NR_L) && (state_q == ST_DRAIN);
    end

    // ---------------- generator next state ----------------
    always_comb begin
        win_d  = win_q;
        i_d    = i_q;
        imod_d = imod_q;
        rcon_d = rcon_q;
        if (load) begin
            for (int j = 0; j < NK; j++) begin
                win_d[j] = key_in_i[32*(NK-j)-1 -: 32];
            end
            i_d    = 6'd0;
            imod_d = 3'd0;
            rcon_d = 8'h01;
        end else if (gen_fire) begin
            for (int j = 0; j < NK - 1; j++) begin
                win_d[j] = win_q[j+1];
            end
            win_d[NK-1] = new_word;
            i_d         = i_q + 6'd1;
            imod_d      = (imod_q == IMOD_LAST) ? 3'd0 : imod_q + 3'd1;
            if (!in_key && rot_sel) begin
                rcon_d = xtime(rcon_q);
            end
        end
    end

    // ---------------- assembly buffer and output register ----------------
    always_comb begin
        asm_d      = asm_q;
        asm_cnt_d  = asm_cnt_q;
        rk_data_d  = rk_data_q;
        rk_idx_d   = rk_idx_q;
        key_cnt_d  = key_cnt_q;
        rk_valid_d = rk_valid_q;
        if (load) begin
            asm_cnt_d = 3'd0;
            key_cnt_d = 4'd0;
        end else begin
            if (xfer) begin
                rk_data_d  = {asm_q[0], asm_q[1], asm_q[2], asm_q[3]};
                rk_idx_d   = key_cnt_q;
                key_cnt_d  = key_cnt_q + 4'd1;
                rk_valid_d = 1'b1;
                asm_cnt_d  = 3'd0;
            end else if (rk_ready_i) begin
                rk_valid_d = 1'b0;
            end
            if (gen_fire) begin
                asm_d[wr_slot] = new_word;
                asm_cnt_d      = xfer ? 3'd1 : asm_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NK; j++) begin
                win_q[j] <= '0;
            end
            for (int j = 0; j < 4; j++) begin
                asm_q[j] <= '0;
            end
            i_q        <= '0;
            imod_q     <= '0;
            rcon_q     <= '0;
            asm_cnt_q  <= '0;
            rk_data_q  <= '0;
            rk_idx_q   <= '0;
            key_cnt_q  <= '0;
            rk_valid_q <= 1'b0;
        end else begin
            win_q      <= win_d;
            asm_q      <= asm_d;
            i_q        <= i_d;
            imod_q     <= imod_d;
            rcon_q     <= rcon_d;
            asm_cnt_q  <= asm_cnt_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
            key_cnt_q  <= key_cnt_d;
            rk_valid_q <= rk_valid_d;
        end
    end

    assign rk_valid_o = rk_valid_q;
    assign rk_data_o  = rk_data_q;
    assign rk_idx_o   = rk_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expand_seq.sv
// ============================================================================
//  tb_aes_key_expand_seq : checks AES-128/192/256 schedules, latency,
//                          backpressure, reset and start handling
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_aes_key_expand_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [2:0]           start, rdy, v, busy, done;
    logic [2:0][127:0]    data;
    logic [2:0][3:0]      idx;
    logic [127:0]         key128;
    logic [191:0]         key192;
    logic [255:0]         key256;

    int tests = 0;
    int fails = 0;

    logic [7:0]   sb [256];
    int           exp_k  [3];
    int           hs_cnt [3];
    logic         armed     [3] = '{default: 1'b0};
    logic         prev_hold [3] = '{default: 1'b0};
    logic [127:0] prev_data [3];
    logic [3:0]   prev_idx  [3];
    logic [255:0] cap_key   [3];

    aes_key_expand_seq #(.NK(4)) dut128 (
        .clk(clk), .rst(rst), .start_i(start[0]), .key_in_i(key128), .busy_o(busy[0]),
        .rk_valid_o(v[0]), .rk_ready_i(rdy[0]), .rk_data_o(data[0]), .rk_idx_o(idx[0]), .done_o(done[0])
    );
    aes_key_expand_seq #(.NK(6)) dut192 (
        .clk(clk), .rst(rst), .start_i(start[1]), .key_in_i(key192), .busy_o(busy[1]),
        .rk_valid_o(v[1]), .rk_ready_i(rdy[1]), .rk_data_o(data[1]), .rk_idx_o(idx[1]), .done_o(done[1])
    );
    aes_key_expand_seq #(.NK(8)) dut256 (
        .clk(clk), .rst(rst), .start_i(start[2]), .key_in_i(key256), .busy_o(busy[2]),
        .rk_valid_o(v[2]), .rk_ready_i(rdy[2]), .rk_data_o(data[2]), .rk_idx_o(idx[2]), .done_o(done[2])
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // ---------------- reference model (FIPS-197 from first principles) -------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_model(input int j);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < j; k++) r = gmul(r, 8'h02);
        return r;
    endfunction

    function automatic logic [127:0] model_rk(input int nk, input logic [255:0] key, input int k);
        logic [31:0] w [60];
        logic [31:0] t;
        int nr;
        nr = nk + 6;
        for (int j = 0; j < nk; j++) w[j] = key[32*(nk-1-j) +: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0)                 t = subw({t[23:0], t[31:24]}) ^ {rcon_model(i / nk), 24'h0};
            else if (nk == 8 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endfunction

    function automatic int nk_of(input int n);
        return (n == 0) ? 4 : (n == 1) ? 6 : 8;
    endfunction

    function automatic logic [255:0] key_of(input int n);
        return (n == 0) ? {128'h0, key128} : (n == 1) ? {64'h0, key192} : key256;
    endfunction

    // ---------------- per-cycle compare against the model --------------------
    always @(negedge clk) begin
        logic de;
        for (int n = 0; n < 3; n++) begin
            if (prev_hold[n]) begin
                chk("stall_valid", 128'(v[n]), 128'd1);
                chk("stall_data", data[n], prev_data[n]);
                chk("stall_idx", 128'(idx[n]), 128'(prev_idx[n]));
            end
            de = armed[n] && v[n] && rdy[n] && (exp_k[n] == nk_of(n) + 6);
            chk("done", 128'(done[n]), 128'(de));
            if (armed[n] && v[n] && rdy[n]) begin
                chk("rk_idx", 128'(idx[n]), 128'(exp_k[n]));
                chk("rk_data", data[n], model_rk(nk_of(n), cap_key[n], exp_k[n]));
                exp_k[n]  = exp_k[n] + 1;
                hs_cnt[n] = hs_cnt[n] + 1;
                if (exp_k[n] > nk_of(n) + 6) armed[n] = 1'b0;
            end else if (!armed[n]) begin
                chk("idle_valid", 128'(v[n]), 128'd0);
            end
            prev_hold[n] = armed[n] && v[n] && !rdy[n] && !rst;
            prev_data[n] = data[n];
            prev_idx[n]  = idx[n];
            if (rst) begin
                armed[n]     = 1'b0;
                prev_hold[n] = 1'b0;
            end else if (start[n] && !busy[n]) begin
                armed[n]   = 1'b1;
                cap_key[n] = key_of(n);
                exp_k[n]   = 0;
                hs_cnt[n]  = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int n, input string tag);
        chk({tag, "_busy"},  128'(busy[n]), 128'd0);
        chk({tag, "_valid"}, 128'(v[n]),    128'd0);
        chk({tag, "_data"},  data[n],       128'd0);
        chk({tag, "_idx"},   128'(idx[n]),  128'd0);
        chk({tag, "_done"},  128'(done[n]), 128'd0);
    endtask

    task automatic run_full(input int n, input bit poke);
        int nr, first_v, done_at;
        logic [127:0] saved;
        nr = nk_of(n) + 6; first_v = -1; done_at = -1; saved = key128;
        start[n] = 1'b1;
        tick();
        start[n] = 1'b0;
        for (int c = 1; c <= 200 && done_at < 0; c++) begin
            if (poke && c == 20) begin key128 = ~saved; start[n] = 1'b1; end
            if (poke && c == 21) start[n] = 1'b0;
            tick();
            if (first_v < 0 && v[n]) first_v = c;
            if (done[n]) done_at = c;
        end
        key128 = saved;
        chk("first_valid_latency", 128'(first_v), 128'd5);
        chk("done_cycle", 128'(done_at), 128'(4 * nr + 5));
        tick();
        chk("busy_after_done", 128'(busy[n]), 128'd0);
        chk("key_count", 128'(hs_cnt[n]), 128'(nr + 1));
    endtask

    task automatic run_bp();
        int hold;
        bit fin;
        hold = 0; fin = 1'b0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int c = 1; c <= 3000 && !fin; c++) begin
            if (v[0] && idx[0] == 4'd3 && hold < 20) begin
                rdy[0] = 1'b0;
                hold++;
            end else begin
                rdy[0] = 1'($urandom_range(0, 1));
            end
            tick();
            if (!busy[0]) fin = 1'b1;
        end
        rdy[0] = 1'b1;
        chk("bp_finished", 128'(fin), 128'd1);
        chk("bp_hold_cycles", 128'(hold), 128'd20);
        chk("bp_key_count", 128'(hs_cnt[0]), 128'd11);
    endtask

    initial begin
        logic [255:0] k;
        bit found;
        rst = 1'b1; start = '0; rdy = '0;
        key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        build_sbox();

        k = {128'h0, key128};
        chk("model128_k0",  model_rk(4, k, 0),  128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("model128_k1",  model_rk(4, k, 1),  128'ha0fafe1788542cb123a339392a6c7605);
        chk("model128_k10", model_rk(4, k, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        k = {64'h0, key192};
        chk("model192_k12", model_rk(6, k, 12), 128'he98ba06f448c773c8ecc720401002202);
        k = key256;
        chk("model256_k14", model_rk(8, k, 14), 128'hfe4890d1e6188d0b046df344706c631e);

        repeat (3) tick();
        for (int n = 0; n < 3; n++) check_zero(n, "reset");
        rst = 1'b0;
        rdy = 3'b111;
        tick();

        run_full(0, 1'b0);
        run_full(0, 1'b1);
        tick();
        run_full(1, 1'b0);
        tick();
        run_full(2, 1'b0);
        tick();

        run_bp();
        tick();

        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            tick();
            if (v[0] && idx[0] == 4'd5) found = 1'b1;
        end
        chk("reached_k5", 128'(found), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero(0, "midrst");
        tick();
        run_full(0, 1'b0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
